tg_edge_window_checker: RTL and testbench

TG_EDGE_WINDOW_CHECKER -- requirements
Module: tg_edge_window_checker

---
 rtl/tg_edge_window_checker.sv | 177 +++++++++++++++++
 tb/tb_tg_edge_window_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tg_edge_window_checker.sv
// rtl/tg_edge_window_checker.sv - multi-channel trigger/response edge timing window checker
module tg_edge_window_checker #(
   parameter int NCH   = 4,
   parameter int DLY_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   C_pur,
   input  logic [NCH-1:0]         chk_en,
   input  logic [NCH-1:0]         trig_in,
   input  logic [NCH-1:0]         resp_in,
   input  logic [NCH-1:0]         trig_pol,
   input  logic [NCH-1:0]         resp_pol,
   input  logic [NCH*DLY_W-1:0]   dly_min,
   input  logic [NCH*DLY_W-1:0]   dly_max,
   input  logic                   clr_cnt,
   output logic [NCH-1:0]         pass_pulse,
   output logic [NCH-1:0]         fail_pulse,
   output logic [2*NCH-1:0]       fail_code,
   output logic [NCH*CNT_W-1:0]   pass_cnt,
   output logic [NCH*CNT_W-1:0]   fail_cnt,
   output logic [NCH-1:0]         err_sticky,
   output logic [NCH-1:0]         armed
);

   typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

   // elapsed counter is one bit wider so dly_max+1 is reachable without wrap
   localparam int KW = DLY_W + 1;

   logic [NCH-1:0] trig_q;
   logic [NCH-1:0] resp_q;
   logic           primed;
   logic [NCH-1:0] trig_edge;
   logic [NCH-1:0] resp_edge;

   // one registered copy of each input; primed masks the first cycle out of reset
   always_ff @(posedge clk or posedge C_pur) begin
      if (C_pur) begin
         trig_q <= '0;
         resp_q <= '0;
         primed <= 1'b0;
      end else begin
         trig_q <= trig_in;
         resp_q <= resp_in;
         primed <= 1'b1;
      end
   end

   assign trig_edge = {NCH{primed}} & ((trig_pol & trig_q & ~trig_in) | (~trig_pol & ~trig_q & trig_in));
   assign resp_edge = {NCH{primed}} & ((resp_pol & resp_q & ~resp_in) | (~resp_pol & ~resp_q & resp_in));

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      state_t             state, state_nx;
      logic [KW-1:0]      k, k_nx;
      logic [DLY_W-1:0]   lmin, lmax, lmin_nx, lmax_nx;
      logic [DLY_W-1:0]   cur_min, cur_max;
      logic               cur_ok;
      logic               ev_pass, ev_fail, arm_req;
      logic [1:0]         ev_code;
      logic               pass_q, fail_q, sticky_q;
      logic [1:0]         code_q;
      logic [CNT_W-1:0]   pcnt, fcnt;

      assign cur_min = dly_min[g*DLY_W +: DLY_W];
      assign cur_max = dly_max[g*DLY_W +: DLY_W];
      assign cur_ok  = (cur_min <= cur_max);

      // decide this cycle's outcome; a concluding response or timeout lets a
      // same-cycle trigger re-arm silently, so at most one event per cycle
      always_comb begin
         state_nx = state;
         k_nx     = k;
         lmin_nx  = lmin;
         lmax_nx  = lmax;
         ev_pass  = 1'b0;
         ev_fail  = 1'b0;
         ev_code  = 2'd0;
         arm_req  = 1'b0;
         if (!chk_en[g]) begin
            state_nx = S_IDLE;
         end else if (state == S_IDLE) begin
            if (trig_edge[g]) begin
               if (!cur_ok) begin
                  ev_fail = 1'b1;
                  ev_code = 2'd3;
               end else if (resp_edge[g]) begin
                  if (cur_min == '0) begin
                     ev_pass = 1'b1;
                  end else begin
                     ev_fail = 1'b1;
                     ev_code = 2'd1;
                  end
               end else begin
                  arm_req = 1'b1;
               end
            end
         end else begin
            if (k == KW'(lmax) + KW'(1)) begin
               ev_fail  = 1'b1;
               ev_code  = 2'd2;
               state_nx = S_IDLE;
               arm_req  = trig_edge[g] & cur_ok;
            end else if (resp_edge[g]) begin
               if (k < KW'(lmin)) begin
                  ev_fail = 1'b1;
                  ev_code = 2'd1;
               end else begin
                  ev_pass = 1'b1;
               end
               state_nx = S_IDLE;
               arm_req  = trig_edge[g] & cur_ok;
            end else if (trig_edge[g]) begin
               ev_fail  = 1'b1;
               ev_code  = 2'd3;
               state_nx = S_IDLE;
               arm_req  = cur_ok;
            end else begin
               k_nx = k + KW'(1);
            end
         end
         if (arm_req) begin
            state_nx = S_ARMED;
            k_nx     = KW'(1);
            lmin_nx  = cur_min;
            lmax_nx  = cur_max;
         end
      end

      // FSM, latched bounds and registered event strobes
      always_ff @(posedge clk or posedge C_pur) begin
         if (C_pur) begin
            state  <= S_IDLE;
            k      <= '0;
            lmin   <= '0;
            lmax   <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            code_q <= 2'd0;
         end else begin
            state  <= state_nx;
            k      <= k_nx;
            lmin   <= lmin_nx;
            lmax   <= lmax_nx;
            pass_q <= ev_pass;
            fail_q <= ev_fail;
            code_q <= ev_code;
         end
      end

      // saturating counters and sticky error; clear wins over increment
      always_ff @(posedge clk or posedge C_pur) begin
         if (C_pur) begin
            pcnt     <= '0;
            fcnt     <= '0;
            sticky_q <= 1'b0;
         end else if (clr_cnt) begin
            pcnt     <= '0;
            fcnt     <= '0;
            sticky_q <= 1'b0;
         end else begin
            if (ev_pass && (pcnt != '1)) pcnt <= pcnt + CNT_W'(1);
            if (ev_fail && (fcnt != '1)) fcnt <= fcnt + CNT_W'(1);
            if (ev_fail) sticky_q <= 1'b1;
         end
      end

      assign pass_pulse[g]              = pass_q;
      assign fail_pulse[g]              = fail_q;
      assign fail_code[2*g +: 2]        = code_q;
      assign pass_cnt[g*CNT_W +: CNT_W] = pcnt;
      assign fail_cnt[g*CNT_W +: CNT_W] = fcnt;
      assign err_sticky[g]              = sticky_q;
      assign armed[g]                   = (state == S_ARMED);
   end

endmodule

// File: tb/tb_tg_edge_window_checker.sv
// tb/tb_tg_edge_window_checker.sv - scoreboard bench for the edge window checker
module tb_tg_edge_window_checker;
   localparam int NCH   = 4;
   localparam int DLY_W = 4;
   localparam int CNT_W = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic clk;
   logic C_pur;
   logic [NCH-1:0] chk_en, trig_in, resp_in, trig_pol, resp_pol;
   logic [NCH*DLY_W-1:0] dly_min, dly_max;
   logic clr_cnt;
   logic [NCH-1:0] pass_pulse, fail_pulse, err_sticky, armed;
   logic [2*NCH-1:0] fail_code;
   logic [NCH*CNT_W-1:0] pass_cnt, fail_cnt;

   tg_edge_window_checker #(.NCH(NCH), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .C_pur(C_pur), .chk_en(chk_en), .trig_in(trig_in), .resp_in(resp_in),
      .trig_pol(trig_pol), .resp_pol(resp_pol), .dly_min(dly_min), .dly_max(dly_max),
      .clr_cnt(clr_cnt), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
      .fail_code(fail_code), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .err_sticky(err_sticky), .armed(armed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0]       pp;
      logic [NCH-1:0]       fp;
      logic [2*NCH-1:0]     code;
      logic [NCH*CNT_W-1:0] pcv;
      logic [NCH*CNT_W-1:0] fcv;
      logic [NCH-1:0]       sticky;
      logic [NCH-1:0]       arm;
   } exp_t;

   exp_t sbq[$];
   int vectors = 0;
   int miscompares = 0;

   // stimulus staged here, copied onto the DUT pins at the falling edge
   logic d_rst, d_clr;
   logic [NCH-1:0] d_en, d_trig, d_resp, d_tpol, d_rpol;
   logic [NCH*DLY_W-1:0] d_mn, d_mx;

   // reference model: pending checks tracked by absolute trigger timestamps
   int  ncyc = 0;
   bit  pv = 0;
   logic [NCH-1:0] p_trig, p_resp;
   bit  pend[NCH];
   int  t0[NCH], lmn[NCH], lmx[NCH], pc[NCH], fc[NCH];
   bit  st[NCH];

   task automatic model_step();
      exp_t e;
      e = '0;
      if (d_rst) begin
         pv = 0;
         for (int ch = 0; ch < NCH; ch++) begin
            pend[ch] = 0; pc[ch] = 0; fc[ch] = 0; st[ch] = 0;
         end
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            bit te, re, vb;
            int mn_in, mx_in, el, ev, code;
            mn_in = int'(d_mn[ch*DLY_W +: DLY_W]);
            mx_in = int'(d_mx[ch*DLY_W +: DLY_W]);
            te = pv && (d_tpol[ch] ? (p_trig[ch] && !d_trig[ch]) : (!p_trig[ch] && d_trig[ch]));
            re = pv && (d_rpol[ch] ? (p_resp[ch] && !d_resp[ch]) : (!p_resp[ch] && d_resp[ch]));
            vb = (mn_in <= mx_in);
            ev = 0; code = 0;
            if (!d_en[ch]) begin
               pend[ch] = 0;
            end else if (!pend[ch]) begin
               if (te) begin
                  if (!vb) begin ev = 2; code = 3; end
                  else if (re) begin
                     if (mn_in == 0) ev = 1;
                     else begin ev = 2; code = 1; end
                  end else begin
                     pend[ch] = 1; t0[ch] = ncyc; lmn[ch] = mn_in; lmx[ch] = mx_in;
                  end
               end
            end else begin
               el = ncyc - t0[ch];
               if (el > lmx[ch]) begin ev = 2; code = 2; end
               else if (re) begin
                  if (el < lmn[ch]) begin ev = 2; code = 1; end
                  else ev = 1;
               end else if (te) begin ev = 2; code = 3; end
               if (ev != 0) begin
                  pend[ch] = 0;
                  if (te && vb) begin
                     pend[ch] = 1; t0[ch] = ncyc; lmn[ch] = mn_in; lmx[ch] = mx_in;
                  end
               end
            end
            if (d_clr) begin
               pc[ch] = 0; fc[ch] = 0; st[ch] = 0;
            end else begin
               if (ev == 1 && pc[ch] < MAXC) pc[ch]++;
               if (ev == 2 && fc[ch] < MAXC) fc[ch]++;
               if (ev == 2) st[ch] = 1;
            end
            e.pp[ch] = (ev == 1);
            e.fp[ch] = (ev == 2);
            e.code[2*ch +: 2] = 2'(code);
            e.pcv[ch*CNT_W +: CNT_W] = CNT_W'(pc[ch]);
            e.fcv[ch*CNT_W +: CNT_W] = CNT_W'(fc[ch]);
            e.sticky[ch] = st[ch];
            e.arm[ch] = pend[ch];
         end
         pv = 1;
         ncyc++;
      end
      p_trig = d_trig;
      p_resp = d_resp;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(negedge clk);
      C_pur = d_rst; clr_cnt = d_clr; chk_en = d_en; trig_in = d_trig; resp_in = d_resp;
      trig_pol = d_tpol; resp_pol = d_rpol; dly_min = d_mn; dly_max = d_mx;
      model_step();
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // monitor: one expected record per sampled cycle, checked just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            cmp("pass_pulse", 32'(pass_pulse), 32'(e.pp));
            cmp("fail_pulse", 32'(fail_pulse), 32'(e.fp));
            cmp("fail_code",  32'(fail_code),  32'(e.code));
            cmp("pass_cnt",   32'(pass_cnt),   32'(e.pcv));
            cmp("fail_cnt",   32'(fail_cnt),   32'(e.fcv));
            cmp("err_sticky", 32'(err_sticky), 32'(e.sticky));
            cmp("armed",      32'(armed),      32'(e.arm));
         end
      end
   end

   initial begin
      C_pur = 1'b1; clr_cnt = 1'b0; chk_en = '0; trig_in = '0; resp_in = '0;
      trig_pol = '0; resp_pol = '0; dly_min = '0; dly_max = '0;
      d_rst = 1; d_clr = 0; d_en = '1; d_trig = '0; d_resp = '0;
      d_tpol = 4'b0010; d_rpol = 4'b0010;
      d_mn = {4'd2, 4'd6, 4'd0, 4'd2};
      d_mx = {4'd5, 4'd3, 4'd0, 4'd5};
      cyc(2);
      d_rst = 0; cyc(3);
      // ch0: in-window pass at k=3
      d_trig[0] = 1; step(); cyc(2);
      d_resp[0] = 1; step();
      d_trig[0] = 0; d_resp[0] = 0; cyc(3);
      // ch0: early response at k=1, bounds change after trigger ignored
      d_trig[0] = 1; step();
      d_mn[3:0] = 4'd0; d_resp[0] = 1; step();
      d_mn[3:0] = 4'd2; d_trig[0] = 0; d_resp[0] = 0; cyc(2);
      // ch0: timeout
      d_trig[0] = 1; step(); cyc(9);
      d_trig[0] = 0; cyc(2);
      // ch1 falling pair (min=max=0) and ch2 inverted bounds
      d_trig[1] = 1; d_resp[1] = 1; cyc(2);
      d_trig[1] = 0; d_resp[1] = 0; d_trig[2] = 1; step();
      d_trig[2] = 0; cyc(3);
      // ch3: retrigger at k=2 then in-window response
      d_trig[3] = 1; step();
      d_trig[3] = 0; step();
      d_trig[3] = 1; step();
      cyc(2); d_resp[3] = 1; step();
      d_trig[3] = 0; d_resp[3] = 0; cyc(3);
      // ch0 saturation with five passes, then clear
      d_mn[3:0] = 4'd0; d_mx[3:0] = 4'd3;
      for (int i = 0; i < 5; i++) begin
         d_trig[0] = 1; step();
         d_resp[0] = 1; step();
         d_trig[0] = 0; d_resp[0] = 0; step();
      end
      d_clr = 1; step();
      d_clr = 0; cyc(2);
      // reset while armed discards the check
      d_trig[0] = 1; step(); step();
      d_rst = 1; cyc(2);
      d_rst = 0; cyc(8);
      // randomized phase
      for (int n = 0; n < 4000; n++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if ($urandom_range(5) == 0) d_trig[ch] = ~d_trig[ch];
            if ($urandom_range(4) == 0) d_resp[ch] = ~d_resp[ch];
            if ($urandom_range(7) == 0) begin
               d_mn[ch*DLY_W +: DLY_W] = 4'($urandom_range(6));
               d_mx[ch*DLY_W +: DLY_W] = 4'($urandom_range(15));
            end
            d_en[ch] = ($urandom_range(39) != 0);
            if ($urandom_range(199) == 0) d_tpol[ch] = ~d_tpol[ch];
            if ($urandom_range(199) == 0) d_rpol[ch] = ~d_rpol[ch];
         end
         d_clr = ($urandom_range(99) == 0);
         d_rst = ($urandom_range(699) == 0);
         step();
      end
      d_rst = 0; d_clr = 0; cyc(3);
      @(posedge clk);
      #3;
      cmp("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
